// File: rtl/pc_ctrl_unit.sv
// Program-counter unit: PC/PC+INC registers, exception trap/ERET, halt FSM.
// Optional return-address stack enabled with the PC_RAS_EN macro.
module pc_ctrl_unit #(
   parameter int unsigned          ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]    RESET_VEC = '0,
   parameter logic [ADDR_W-1:0]    TRAP_VEC  = ADDR_W'(32'h0000_0080),
   parameter int unsigned          INC       = 4,
   parameter int unsigned          RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_wre,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              exc,
   input  logic              eret,
   input  logic              halt,
   input  logic              resume,
   input  logic              call,
   input  logic              ret,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] pc4,
   output logic [ADDR_W-1:0] epc,
   output logic              in_trap,
   output logic              halted
`ifdef PC_RAS_EN
   ,
   output logic              ras_empty
`endif
);

   localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

   typedef enum logic {RUN, HALT} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, pc4_q, epc_q, epc_d;
   logic              in_trap_q, in_trap_d;
   logic              push, pop;
   logic              ras_hit;
   logic [ADDR_W-1:0] ras_top;

`ifdef PC_RAS_EN
   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr_q, ptr_d, top_idx;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign top_idx   = ptr_q - PTR_W'(1);
   assign ras_top   = ras_mem[top_idx];
   assign ras_hit   = (cnt_q != '0);
   assign ras_empty = (cnt_q == '0);
`else
   logic unused_ras_inputs;
   assign unused_ras_inputs = call ^ ret;
   assign ras_top = '0;
   assign ras_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      epc_d     = epc_q;
      in_trap_d = in_trap_q;
      push      = 1'b0;
      pop       = 1'b0;

      unique case (state_q)
         RUN:  if (halt && !resume) state_d = HALT;
         HALT: if (resume && !halt) state_d = RUN;
         default: state_d = RUN;
      endcase

      // Exceptions are taken in both states; a trap inside a trap keeps the first EPC.
      if (exc) begin
         pc_d      = TRAP_VEC;
         in_trap_d = 1'b1;
         if (!in_trap_q) epc_d = pc_q;
      end else if (state_q == RUN) begin
         if (eret && in_trap_q) begin
            pc_d      = epc_q;
            in_trap_d = 1'b0;
         end else if (!halt && pc_wre) begin
            push = call;
            if (ret && ras_hit) begin
               pc_d = ras_top;
               pop  = 1'b1;
            end else begin
               pc_d = pc_in;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= RUN;
         pc_q      <= RESET_VEC;
         pc4_q     <= RESET_VEC + INC_V;
         epc_q     <= '0;
         in_trap_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pc4_q     <= pc_d + INC_V;
         epc_q     <= epc_d;
         in_trap_q <= in_trap_d;
      end
   end

`ifdef PC_RAS_EN
   // Pop+push replaces the top in place; a push when full overwrites the oldest slot.
   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10: begin
            ptr_d = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
         end
         2'b01: begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && push) ras_mem[pop ? top_idx : ptr_q] <= pc4_q;
   end
`else
   logic unused_ras_ctl;
   assign unused_ras_ctl = push ^ pop ^ (|ras_top);
`endif

   assign pc_out  = pc_q;
   assign pc4     = pc4_q;
   assign epc     = epc_q;
   assign in_trap = in_trap_q;
   assign halted  = (state_q == HALT);

endmodule

// File: tb/tb_pc_ctrl_unit.sv
// Directed self-checking bench for pc_ctrl_unit; RAS scenarios run when PC_RAS_EN is defined.
module tb_pc_ctrl_unit;

   logic        clk = 1'b0;
   logic        reset, pc_wre, exc, eret, halt, resume, call, ret;
   logic [31:0] pc_in, pc_out, pc4, epc;
   logic        in_trap, halted, ras_empty;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   pc_ctrl_unit dut (
      .clk(clk), .reset(reset), .pc_wre(pc_wre), .pc_in(pc_in),
      .exc(exc), .eret(eret), .halt(halt), .resume(resume),
      .call(call), .ret(ret),
      .pc_out(pc_out), .pc4(pc4), .epc(epc), .in_trap(in_trap), .halted(halted)
`ifdef PC_RAS_EN
      , .ras_empty(ras_empty)
`endif
   );

`ifndef PC_RAS_EN
   assign ras_empty = 1'b1;
`endif

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; pc_wre = 1'b1; pc_in = 32'h40;
      step(); step();
      checks++; if ({pc_out, pc4} !== {32'h0, 32'h4}) begin errors++;
         $display("FAIL reset_pc: got %h/%h want 0/4", pc_out, pc4); end
      checks++; if ({epc, in_trap, halted, ras_empty} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin errors++;
         $display("FAIL reset_state: got epc=%h trap=%b halt=%b empty=%b", epc, in_trap, halted, ras_empty); end
      reset = 1'b1;
      step();
      checks++; if ({pc_out, pc4} !== {32'h40, 32'h44}) begin errors++;
         $display("FAIL reset_release: got %h/%h want 40/44", pc_out, pc4); end
   endtask

   task automatic test_stall();
      pc_in = 32'h100;
      step();
      pc_wre = 1'b0; pc_in = 32'h200;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if ({pc_out, pc4} !== {32'h100, 32'h104}) begin errors++;
            $display("FAIL stall_%0d: got %h/%h want 100/104", i, pc_out, pc4); end
      end
      pc_wre = 1'b1;
      step();
      checks++; if ({pc_out, pc4} !== {32'h200, 32'h204}) begin errors++;
         $display("FAIL stall_release: got %h/%h want 200/204", pc_out, pc4); end
   endtask

   task automatic test_wrap();
      pc_in = 32'hFFFF_FFFC;
      step();
      checks++; if ({pc_out, pc4} !== {32'hFFFF_FFFC, 32'h0}) begin errors++;
         $display("FAIL wrap: got %h/%h want fffffffc/0", pc_out, pc4); end
   endtask

   task automatic test_trap();
      pc_in = 32'h20;
      step();
      exc = 1'b1;
      step();
      exc = 1'b0; pc_in = 32'h84;
      checks++; if ({pc_out, pc4, epc, in_trap} !== {32'h80, 32'h84, 32'h20, 1'b1}) begin errors++;
         $display("FAIL trap_entry: got pc=%h pc4=%h epc=%h trap=%b", pc_out, pc4, epc, in_trap); end
      step();
      checks++; if (pc_out !== 32'h84) begin errors++;
         $display("FAIL trap_step: got %h want 84", pc_out); end
      exc = 1'b1;
      step();
      exc = 1'b0;
      checks++; if ({pc_out, epc, in_trap} !== {32'h80, 32'h20, 1'b1}) begin errors++;
         $display("FAIL trap_nested: got pc=%h epc=%h trap=%b", pc_out, epc, in_trap); end
      eret = 1'b1;
      step();
      checks++; if ({pc_out, pc4, in_trap} !== {32'h20, 32'h24, 1'b0}) begin errors++;
         $display("FAIL eret: got pc=%h pc4=%h trap=%b", pc_out, pc4, in_trap); end
      pc_in = 32'h60;
      step();
      eret = 1'b0;
      checks++; if ({pc_out, in_trap} !== {32'h60, 1'b0}) begin errors++;
         $display("FAIL eret_no_trap: got pc=%h trap=%b want 60/0", pc_out, in_trap); end
   endtask

   task automatic test_halt();
      pc_in = 32'h30;
      step();
      halt = 1'b1; pc_in = 32'h34;
      step();
      halt = 1'b0;
      checks++; if ({pc_out, halted} !== {32'h30, 1'b1}) begin errors++;
         $display("FAIL halt_enter: got pc=%h halted=%b want 30/1", pc_out, halted); end
      for (int i = 0; i < 5; i++) begin
         pc_in = 32'h100 + 32'(i) * 4;
         step();
         checks++; if ({pc_out, pc4, halted} !== {32'h30, 32'h34, 1'b1}) begin errors++;
            $display("FAIL halt_hold_%0d: got pc=%h pc4=%h halted=%b", i, pc_out, pc4, halted); end
      end
      resume = 1'b1; pc_in = 32'h300;
      step();
      resume = 1'b0;
      checks++; if ({pc_out, halted} !== {32'h30, 1'b0}) begin errors++;
         $display("FAIL resume: got pc=%h halted=%b want 30/0", pc_out, halted); end
      step();
      checks++; if ({pc_out, pc4} !== {32'h300, 32'h304}) begin errors++;
         $display("FAIL resume_step: got %h/%h want 300/304", pc_out, pc4); end
   endtask

`ifdef PC_RAS_EN
   task automatic test_ras();
      logic [31:0] exp;
      pc_in = 32'hC;
      step();
      call = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pc_in = 32'h1C + 32'(i) * 32'h10;
         step();
      end
      call = 1'b0;
      checks++; if ({pc_out, ras_empty} !== {32'h5C, 1'b0}) begin errors++;
         $display("FAIL ras_push: got pc=%h empty=%b want 5c/0", pc_out, ras_empty); end
      ret = 1'b1; pc_in = 32'h700;
      for (int i = 0; i < 4; i++) begin
         exp = 32'h50 - 32'(i) * 32'h10;
         step();
         checks++; if ({pc_out, pc4} !== {exp, exp + 32'h4}) begin errors++;
            $display("FAIL ras_pop_%0d: got %h/%h want %h", i, pc_out, pc4, exp); end
      end
      step();
      ret = 1'b0;
      checks++; if ({pc_out, ras_empty} !== {32'h700, 1'b1}) begin errors++;
         $display("FAIL ras_empty_pop: got pc=%h empty=%b want 700/1", pc_out, ras_empty); end
      pc_in = 32'h200;
      step();
      call = 1'b1; pc_in = 32'h300;
      step();
      ret = 1'b1;
      step();
      call = 1'b0;
      checks++; if ({pc_out, ras_empty} !== {32'h204, 1'b0}) begin errors++;
         $display("FAIL ras_call_ret: got pc=%h empty=%b want 204/0", pc_out, ras_empty); end
      step();
      ret = 1'b0;
      checks++; if ({pc_out, ras_empty} !== {32'h304, 1'b1}) begin errors++;
         $display("FAIL ras_replaced_top: got pc=%h empty=%b want 304/1", pc_out, ras_empty); end
   endtask
`else
   task automatic test_ras();
      call = 1'b1; ret = 1'b1; pc_in = 32'h440;
      step();
      call = 1'b0; ret = 1'b0;
      checks++; if (pc_out !== 32'h440) begin errors++;
         $display("FAIL ras_absent: got %h want 440", pc_out); end
   endtask
`endif

   task automatic test_reset_mid();
      pc_in = 32'h30;
      step();
      halt = 1'b1;
      step();
      halt = 1'b0; exc = 1'b1;
      step();
      exc = 1'b0;
      checks++; if ({pc_out, epc, in_trap, halted} !== {32'h80, 32'h30, 1'b1, 1'b1}) begin errors++;
         $display("FAIL halt_exc: got pc=%h epc=%h trap=%b halted=%b", pc_out, epc, in_trap, halted); end
      reset = 1'b0; eret = 1'b1; resume = 1'b1;
      step();
      eret = 1'b0; resume = 1'b0;
      checks++; if ({pc_out, pc4, epc, in_trap, halted, ras_empty} !==
                    {32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b1}) begin errors++;
         $display("FAIL reset_mid: got pc=%h pc4=%h epc=%h trap=%b halted=%b empty=%b",
                  pc_out, pc4, epc, in_trap, halted, ras_empty); end
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; pc_wre = 1'b0; pc_in = '0; exc = 1'b0; eret = 1'b0;
      halt = 1'b0; resume = 1'b0; call = 1'b0; ret = 1'b0;
      test_reset();
      test_stall();
      test_wrap();
      test_trap();
      test_halt();
      test_ras();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
